// File: rtl/ps2_command_out.sv
// ps2_command_out: PS/2 host-to-device command transmitter.
// It inhibits the bus, issues a start bit, and shifts out the data byte, odd parity and stop bit
// on device clock falling edges. It then samples the device ACK and reports one status pulse.
// Optional feature: define PS2_COMMAND_OUT_TIMEOUT_EN to enable the start and transfer timeouts.
module ps2_command_out #(
    parameter int unsigned CLK_INHIBIT_CYCLES   = 5000,
    parameter int unsigned START_TIMEOUT_CYCLES = 750000,
    parameter int unsigned XFER_TIMEOUT_CYCLES  = 100000
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic [7:0] the_command,
    input  logic       send_command,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DAT,
    output logic       busy,
    output logic       command_was_sent,
    output logic       error_no_ack,
    output logic       error_communication_timed_out
);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ_START,
        SEND,
        WAIT_ACK,
        WAIT_RELEASE
    } state_t;

    localparam int unsigned INH_W = (CLK_INHIBIT_CYCLES > 1) ? $clog2(CLK_INHIBIT_CYCLES) : 1;

    state_t           state;
    state_t           state_next;
    logic [1:0]       clk_sync;
    logic [1:0]       dat_sync;
    logic             clk_prev;
    logic             clk_s;
    logic             dat_s;
    logic             fall;
    logic [9:0]       frame;          // {stop, parity, data[7:0]}; bit 0 goes out first
    logic [3:0]       bit_count;
    logic [INH_W-1:0] inhibit_count;
    logic             inhibit_done;
    logic             ack_bit;
    logic             accept;
    logic             sent_next;
    logic             nack_next;
    logic             clk_low;
    logic             dat_low;

    assign clk_s        = clk_sync[1];
    assign dat_s        = dat_sync[1];
    assign fall         = clk_prev & ~clk_s;
    assign inhibit_done = (inhibit_count == INH_W'(CLK_INHIBIT_CYCLES - 1));
    assign busy         = (state != IDLE);

    // The bus is open-drain: the host only ever pulls low or releases.
    assign clk_low = (state == INHIBIT);
    assign dat_low = (state == REQ_START) || ((state == SEND) && !frame[bit_count]);
    assign PS2_CLK = clk_low ? 1'b0 : 1'bz;
    assign PS2_DAT = dat_low ? 1'b0 : 1'bz;

    // Two-flop synchronizers plus a history flop for falling-edge detection; idle bus reads high.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], PS2_CLK};
            dat_sync <= {dat_sync[0], PS2_DAT};
            clk_prev <= clk_s;
        end
    end

`ifdef PS2_COMMAND_OUT_TIMEOUT_EN
    localparam int unsigned TMO_MAX = (START_TIMEOUT_CYCLES > XFER_TIMEOUT_CYCLES) ?
                                      START_TIMEOUT_CYCLES : XFER_TIMEOUT_CYCLES;
    localparam int unsigned TMO_W   = $clog2(TMO_MAX + 1);

    logic [TMO_W-1:0] timer;
    logic             timeout_hit;
    logic             tmo_next;

    // A device clock edge in REQ_START wins over a simultaneous start-timeout expiry.
    assign timeout_hit =
        ((state == REQ_START) && !fall && (timer == TMO_W'(START_TIMEOUT_CYCLES - 1))) ||
        ((state inside {SEND, WAIT_ACK, WAIT_RELEASE}) &&
         (timer == TMO_W'(XFER_TIMEOUT_CYCLES - 1)));
    assign tmo_next = timeout_hit;

    // Timeout timer: restarts on REQ_START entry and again on SEND entry.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            timer                         <= '0;
            error_communication_timed_out <= 1'b0;
        end else begin
            error_communication_timed_out <= tmo_next;
            if ((state == IDLE) || (state == INHIBIT) || ((state == REQ_START) && fall)) begin
                timer <= '0;
            end else begin
                timer <= timer + TMO_W'(1);
            end
        end
    end
`else
    assign error_communication_timed_out = 1'b0;
`endif

    // Next-state and status-pulse decode.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        sent_next  = 1'b0;
        nack_next  = 1'b0;
        case (state)
            IDLE: begin
                if (send_command) begin
                    accept     = 1'b1;
                    state_next = INHIBIT;
                end
            end
            INHIBIT: begin
                if (inhibit_done) state_next = REQ_START;
            end
            REQ_START: begin
                if (fall) state_next = SEND;
            end
            SEND: begin
                if (fall && (bit_count == 4'd8)) state_next = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (fall) state_next = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                if (clk_s && dat_s) begin
                    state_next = IDLE;
                    sent_next  = ack_bit;
                    nack_next  = ~ack_bit;
                end
            end
            default: state_next = IDLE;
        endcase
`ifdef PS2_COMMAND_OUT_TIMEOUT_EN
        if (timeout_hit) begin
            state_next = IDLE;
            sent_next  = 1'b0;
            nack_next  = 1'b0;
        end
`endif
    end

    // State register, frame latch, bit/inhibit counters, ACK capture and status pulses.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state            <= IDLE;
            frame            <= '0;
            bit_count        <= '0;
            inhibit_count    <= '0;
            ack_bit          <= 1'b0;
            command_was_sent <= 1'b0;
            error_no_ack     <= 1'b0;
        end else begin
            state            <= state_next;
            command_was_sent <= sent_next;
            error_no_ack     <= nack_next;
            if (accept) begin
                frame <= {1'b1, ~^the_command, the_command};
            end
            if ((state == INHIBIT) && !inhibit_done) begin
                inhibit_count <= inhibit_count + INH_W'(1);
            end else begin
                inhibit_count <= '0;
            end
            if (state == REQ_START) begin
                bit_count <= '0;
            end else if ((state == SEND) && fall) begin
                bit_count <= bit_count + 4'd1;
            end
            if ((state == WAIT_ACK) && fall) begin
                ack_bit <= ~dat_s;
            end
        end
    end

endmodule

// File: tb/tb_ps2_command_out.sv
// tb_ps2_command_out: directed plus randomized bench for ps2_command_out with a behavioural
// PS/2 device model (40-cycle device clock) and a frame reference model built from byte values.
// Honors PS2_COMMAND_OUT_TIMEOUT_EN the same way as the design.
`timescale 1ns/1ps
module tb_ps2_command_out;

    localparam int INH  = 20;
    localparam int STO  = 200;
    localparam int XTO  = 2000;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       send_command = 1'b0;
    logic [7:0] the_command = 8'h00;
    wire        ps2_clk;
    wire        ps2_dat;
    logic       busy;
    logic       command_was_sent;
    logic       error_no_ack;
    logic       error_communication_timed_out;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;

    pullup (ps2_clk);
    pullup (ps2_dat);
    assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;

    int checks = 0;
    int errors = 0;
    int n_sent = 0;
    int n_nack = 0;
    int n_tmo = 0;
    int align_bad = 0;
    logic busy_q = 1'b0;

    ps2_command_out #(
        .CLK_INHIBIT_CYCLES  (INH),
        .START_TIMEOUT_CYCLES(STO),
        .XFER_TIMEOUT_CYCLES (XTO)
    ) dut (
        .CLOCK_50                     (clk),
        .reset_n                      (reset_n),
        .the_command                  (the_command),
        .send_command                 (send_command),
        .PS2_CLK                      (ps2_clk),
        .PS2_DAT                      (ps2_dat),
        .busy                         (busy),
        .command_was_sent             (command_was_sent),
        .error_no_ack                 (error_no_ack),
        .error_communication_timed_out(error_communication_timed_out)
    );

    always #5 clk = ~clk;

    // Pulse counters; every status pulse must coincide with busy falling.
    always @(negedge clk) begin
        if (command_was_sent === 1'b1) n_sent++;
        if (error_no_ack === 1'b1) n_nack++;
        if (error_communication_timed_out === 1'b1) n_tmo++;
        if ((command_was_sent | error_no_ack | error_communication_timed_out) === 1'b1 &&
            (busy !== 1'b0 || busy_q !== 1'b1)) align_bad++;
        busy_q = busy;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference frame as the device sees it on rising edges: D0..D7, odd parity, stop.
    function automatic logic [9:0] expect_bits(input logic [7:0] c);
        logic par;
        par = ($countones(c) % 2 == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, c};
    endfunction

    // Request a send and measure how long the host holds the clock low.
    task automatic start_send(input logic [7:0] cmd, output int low_cycles);
        the_command  = cmd;
        send_command = 1'b1;
        tick(1);
        send_command = 1'b0;
        the_command  = 8'($urandom);
        low_cycles   = 0;
        while (ps2_clk === 1'b0 && low_cycles < 1000) begin
            low_cycles++;
            tick(1);
        end
    endtask

    // Device clocks out 10 bits, then handles the ACK slot; optionally injects a send request.
    task automatic device_xfer(input logic ack, input int inject_bit, input logic [7:0] inj_cmd,
                               output logic [9:0] seen);
        for (int k = 0; k < 10; k++) begin
            tick(HALF);
            dev_clk_low = 1'b1;
            if (k == inject_bit) begin
                tick(2);
                the_command  = inj_cmd;
                send_command = 1'b1;
                tick(1);
                send_command = 1'b0;
                tick(HALF - 3);
            end else begin
                tick(HALF);
            end
            seen[k]     = ps2_dat;
            dev_clk_low = 1'b0;
        end
        tick(HALF / 2);
        if (ack) dev_dat_low = 1'b1;
        tick(HALF / 2);
        dev_clk_low = 1'b1;
        tick(HALF);
        dev_clk_low = 1'b0;
        tick(HALF / 2);
        dev_dat_low = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int cyc;
        cyc = 0;
        while (busy !== 1'b0 && cyc < 300) begin
            cyc++;
            tick(1);
        end
        check({tag, ":busy_drop"}, 32'(busy), 32'd0);
    endtask

    task automatic run_txn(input logic [7:0] cmd, input logic ack, input int inject_bit,
                           input string tag);
        int low;
        int s0, n0, t0, a0;
        logic [9:0] seen;
        s0 = n_sent; n0 = n_nack; t0 = n_tmo; a0 = align_bad;
        start_send(cmd, low);
        check({tag, ":inhibit_len"}, 32'(low), 32'(INH));
        check({tag, ":start_bit"}, 32'(ps2_dat), 32'd0);
        device_xfer(ack, inject_bit, 8'h33, seen);
        wait_idle(tag);
        tick(2);
        check({tag, ":bits"}, 32'(seen), 32'(expect_bits(cmd)));
        check({tag, ":sent_pulses"}, 32'(n_sent - s0), ack ? 32'd1 : 32'd0);
        check({tag, ":nack_pulses"}, 32'(n_nack - n0), ack ? 32'd0 : 32'd1);
        check({tag, ":tmo_pulses"}, 32'(n_tmo - t0), 32'd0);
        check({tag, ":pulse_busy_align"}, 32'(align_bad - a0), 32'd0);
        check({tag, ":lines_idle"}, {30'd0, ps2_clk, ps2_dat}, 32'd3);
    endtask

    initial begin
        int low;
        int s0, n0, t0;
        logic [7:0] rc;
        logic       rack;
        logic [9:0] seen;

        // Reset state
        reset_n = 1'b0;
        tick(3);
        check("rst:busy", 32'(busy), 32'd0);
        check("rst:pulses", {29'd0, command_was_sent, error_no_ack, error_communication_timed_out}, 32'd0);
        check("rst:lines", {30'd0, ps2_clk, ps2_dat}, 32'd3);
        reset_n = 1'b1;
        tick(1);

        // 0xED acknowledged
        run_txn(8'hED, 1'b1, -1, "ed_ack");

        // 0xF4 then 0x00 back to back, parity 0 then 1
        s0 = n_sent;
        start_send(8'hF4, low);
        device_xfer(1'b1, -1, 8'h00, seen);
        wait_idle("f4");
        check("f4:parity", 32'(seen[8]), 32'd0);
        start_send(8'h00, low);
        device_xfer(1'b1, -1, 8'h00, seen);
        wait_idle("00");
        tick(2);
        check("00:parity", 32'(seen[8]), 32'd1);
        check("b2b:sent_pulses", 32'(n_sent - s0), 32'd2);

        // 0xFF not acknowledged
        run_txn(8'hFF, 1'b0, -1, "ff_nack");

        // 0x55, device never clocks
        t0 = n_tmo;
        start_send(8'h55, low);
        check("tmo:inhibit_len", 32'(low), 32'(INH));
`ifdef PS2_COMMAND_OUT_TIMEOUT_EN
        low = 0;
        while (ps2_dat === 1'b0 && low < 1000) begin
            low++;
            tick(1);
        end
        tick(2);
        check("tmo:req_start_len", 32'(low), 32'(STO));
        check("tmo:pulse", 32'(n_tmo - t0), 32'd1);
        check("tmo:busy", 32'(busy), 32'd0);
        check("tmo:lines", {30'd0, ps2_clk, ps2_dat}, 32'd3);
`else
        tick(500);
        check("notmo:busy_held", 32'(busy), 32'd1);
        check("notmo:no_pulse", 32'(n_tmo - t0), 32'd0);
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(1);
        check("notmo:recovered", 32'(busy), 32'd0);
`endif

        // 0xAA aborted by reset after falling edge 4
        s0 = n_sent; n0 = n_nack; t0 = n_tmo;
        start_send(8'hAA, low);
        for (int k = 0; k < 3; k++) begin
            tick(HALF);
            dev_clk_low = 1'b1;
            tick(HALF);
            dev_clk_low = 1'b0;
        end
        tick(HALF);
        dev_clk_low = 1'b1;
        tick(5);
        reset_n = 1'b0;
        tick(1);
        check("abort:busy", 32'(busy), 32'd0);
        check("abort:dat_released", 32'(ps2_dat), 32'd1);
        dev_clk_low = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(3);
        check("abort:no_pulses", 32'((n_sent - s0) + (n_nack - n0) + (n_tmo - t0)), 32'd0);
        run_txn(8'h12, 1'b1, -1, "after_abort");

        // 0x33 request during a 0xED transfer is ignored
        run_txn(8'hED, 1'b1, 3, "ignore_33");
        check("ignore_33:still_idle", 32'(busy), 32'd0);

        // Randomized commands and ACK/NACK
        for (int i = 0; i < 6; i++) begin
            rc   = 8'($urandom);
            rack = 1'($urandom_range(0, 1));
            run_txn(rc, rack, -1, $sformatf("rand%0d_%02h", i, rc));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
